// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and delivered-instruction counter.
// Redirects beat stalls and always leave exactly one bubble in IF/ID.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0004,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic [31:0] fetch_count
);

   typedef enum logic {BUBBLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_en;

   assign fetch_en    = !redirect_valid && !stall;
   assign pc_plus4    = pc + 32'd4;
   assign imem_addr   = pc;
   assign if_id_valid = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= BUBBLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (redirect_valid)
         state_nxt = BUBBLE;
      else if (!stall)
         state_nxt = RUN;
   end

   // Misaligned redirect targets are silently word-aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC;
      else if (redirect_valid)
         pc <= {redirect_pc[31:2], 2'b00};
      else if (fetch_en)
         pc <= pc_plus4;
   end

   // On redirect the PC fields are left alone; only the instruction is squashed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_pc       <= 32'd0;
         if_id_pc_plus4 <= 32'd0;
         if_id_instr    <= NOP_INSTR;
         fetch_count    <= 32'd0;
      end else if (redirect_valid) begin
         if_id_instr    <= NOP_INSTR;
      end else if (fetch_en) begin
         if_id_pc       <= pc;
         if_id_pc_plus4 <= pc_plus4;
         if_id_instr    <= imem_instr;
         fetch_count    <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed corner cases followed by randomized stall/redirect/reset traffic
// checked against a transaction-level model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0004;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
   logic        m_v;

   fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_instr = mem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_v = 1'b0; m_ipc = 32'd0; m_ipc4 = 32'd0; m_instr = NOP; m_cnt = 32'd0;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_addr"},  imem_addr,              m_pc);
      chk({tag, "_valid"}, {31'd0, if_id_valid},   {31'd0, m_v});
      chk({tag, "_pc"},    if_id_pc,               m_ipc);
      chk({tag, "_pc4"},   if_id_pc_plus4,         m_ipc4);
      chk({tag, "_instr"}, if_id_instr,            m_instr);
      chk({tag, "_cnt"},   fetch_count,            m_cnt);
   endtask

   // one rising edge: advance model with the inputs seen at the edge, then compare
   task automatic step(input string tag);
      @(posedge clk);
      if (redirect_valid) begin
         m_pc    = redirect_pc & 32'hFFFF_FFFC;
         m_v     = 1'b0;
         m_instr = NOP;
      end else if (!stall) begin
         m_ipc   = m_pc;
         m_ipc4  = m_pc + 32'd4;
         m_instr = mem_word(m_pc);
         m_v     = 1'b1;
         m_pc    = m_pc + 32'd4;
         m_cnt   = m_cnt + 32'd1;
      end
      #1;
      chk_all(tag);
   endtask

   task automatic drive(input logic s, input logic r, input logic [31:0] rp);
      stall = s; redirect_valid = r; redirect_pc = rp;
   endtask

   task automatic async_reset_pulse(input string tag);
      rst_n = 1'b0;
      #2;
      model_reset();
      chk_all(tag);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'd0);
      model_reset();
      #12;
      chk_all("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // three free-running fetches from the reset PC
      step("f1"); chk("f1_pc_k", if_id_pc, 32'd4);
      step("f2"); chk("f2_pc_k", if_id_pc, 32'd8);
      step("f3"); chk("f3_pc_k", if_id_pc, 32'd12);
      chk("f3_cnt_k", fetch_count, 32'd3);
      chk("f3_addr_k", imem_addr, 32'd16);

      // reach PC=20, then redirect to a misaligned target
      step("f4");
      chk("f4_addr_k", imem_addr, 32'd20);
      drive(1'b0, 1'b1, 32'h0000_0042);
      step("rd");
      chk("rd_addr_k", imem_addr, 32'h40);
      chk("rd_valid_k", {31'd0, if_id_valid}, 32'd0);
      chk("rd_instr_k", if_id_instr, 32'h13);
      drive(1'b0, 1'b0, 32'd0);
      step("rd1");
      chk("rd1_pc_k", if_id_pc, 32'h40);
      chk("rd1_valid_k", {31'd0, if_id_valid}, 32'd1);

      // get to PC=12 and hold for four stalled edges
      drive(1'b0, 1'b1, 32'd8);
      step("go8");
      drive(1'b0, 1'b0, 32'd0);
      step("f8");
      drive(1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) step("stl");
      chk("stl_addr_k", imem_addr, 32'd12);
      drive(1'b0, 1'b0, 32'd0);
      step("rel");
      chk("rel_pc_k", if_id_pc, 32'd12);

      // redirect wins over stall
      drive(1'b1, 1'b1, 32'h100);
      step("sr");
      chk("sr_addr_k", imem_addr, 32'h100);
      chk("sr_valid_k", {31'd0, if_id_valid}, 32'd0);

      // PC wrap at the top of the address space
      drive(1'b0, 1'b1, 32'hFFFF_FFFC);
      step("wr");
      drive(1'b0, 1'b0, 32'd0);
      step("wr1");
      chk("wr1_pc_k", if_id_pc, 32'hFFFF_FFFC);
      chk("wr1_pc4_k", if_id_pc_plus4, 32'd0);
      chk("wr1_addr_k", imem_addr, 32'd0);

      // asynchronous reset between edges while PC=0x50, with a stall pending
      drive(1'b0, 1'b1, 32'h50);
      step("p50");
      step("p50b");
      drive(1'b1, 1'b0, 32'd0);
      async_reset_pulse("arst");
      chk("arst_addr_k", imem_addr, RST_PC);
      drive(1'b0, 1'b0, 32'd0);
      step("arst1");
      chk("arst1_pc_k", if_id_pc, RST_PC);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, $urandom());
         if ($urandom_range(0, 199) == 0) begin
            drive(1'b0, 1'b1, $urandom());
            async_reset_pulse("rrst");
         end
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
